// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: state encodings and default widths shared by the user-I/O controller.
package io_ctrl_pkg;
   typedef enum logic [2:0] {
      RUN            = 3'd0,
      IN_WAIT_PRESS  = 3'd1,
      IN_WAIT_REL    = 3'd2,
      IN_COMMIT      = 3'd3,
      OUT_WAIT_PRESS = 3'd4,
      OUT_WAIT_REL   = 3'd5,
      OUT_COMMIT     = 3'd6,
      HALTED         = 3'd7
   } io_state_t;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_SW_W     = 16;
   localparam int DEF_DEBOUNCE = 4;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchronizer and stable-count filter producing 1-cycle press/release pulses.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press,
   output logic rel
);
   logic [1:0] sync;
   logic [7:0] cnt;
   logic       level;
   logic       hit;
   // the level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample
   assign hit = (sync[1] != level) && (cnt == 8'(DEBOUNCE_CYCLES - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         cnt   <= (sync[1] == level || hit) ? 8'd0 : cnt + 8'd1;
         level <= hit ? sync[1] : level;
         press <= hit & sync[1];
         rel   <= hit & ~sync[1];
      end
endmodule

// File: rtl/io_handshake_ctrl.sv
// io_handshake_ctrl: sequences user-I/O instructions against the operator button.
// Define SW_SIGN_EXT_EN to sign-extend the switches into user_input (default: zero-extend).
module io_handshake_ctrl import io_ctrl_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int SW_W            = DEF_SW_W
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              insert,
   input  logic [SW_W-1:0]   SW,
   input  logic              input_flag,
   input  logic              output_flag,
   input  logic              halt,
   input  logic [DATA_W-1:0] reg_data,
   output logic              pc_stall,
   output logic [DATA_W-1:0] user_input,
   output logic [DATA_W-1:0] display_value,
   output logic              display_valid,
   output logic              halted,
   output logic [2:0]        state_dbg
);
   io_state_t         state, state_nx;
   logic              press, rel;
   logic [DATA_W-1:0] sw_ext;
`ifdef SW_SIGN_EXT_EN
   assign sw_ext = DATA_W'($signed(SW));
`else
   assign sw_ext = DATA_W'(SW);
`endif
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk  (CLK),
      .rst_n(reset),
      .btn  (insert),
      .press(press),
      .rel  (rel)
   );
   always_comb begin
      state_nx = state;
      case (state)
         RUN:                   state_nx = halt ? HALTED : input_flag ? IN_WAIT_PRESS : output_flag ? OUT_WAIT_PRESS : RUN;
         IN_WAIT_PRESS:         state_nx = press ? IN_WAIT_REL : state;
         IN_WAIT_REL:           state_nx = rel ? IN_COMMIT : state;
         IN_COMMIT, OUT_COMMIT: state_nx = RUN;
         OUT_WAIT_PRESS:        state_nx = press ? OUT_WAIT_REL : state;
         OUT_WAIT_REL:          state_nx = rel ? OUT_COMMIT : state;
         default:               state_nx = HALTED;
      endcase
   end
   // RUN stalls combinationally so the PC never steps past an I/O instruction
   always_comb begin
      pc_stall  = 1'b0;
      pc_stall  = reset && ((state == RUN) ? (halt | input_flag | output_flag) : (state != IN_COMMIT && state != OUT_COMMIT));
      halted    = (state == HALTED);
      state_dbg = state;
   end
   always_ff @(posedge CLK or negedge reset)
      if (!reset) begin
         state         <= RUN;
         user_input    <= '0;
         display_value <= '0;
         display_valid <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IN_WAIT_PRESS && press) user_input <= sw_ext;
         if (state == RUN && !halt && !input_flag && output_flag) begin
            display_value <= reg_data;
            display_valid <= 1'b1;
         end
      end
endmodule

// File: tb/tb_io_handshake_ctrl.sv
// tb_io_handshake_ctrl: table, directed and randomized checks against a spec-level reference model.
module tb_io_handshake_ctrl;
   localparam int D = 4;
   logic        CLK = 1'b0, reset = 1'b0, insert = 1'b0;
   logic        input_flag = 1'b0, output_flag = 1'b0, halt = 1'b0;
   logic [15:0] SW = '0;
   logic [31:0] reg_data = '0;
   logic        pc_stall, display_valid, halted;
   logic [31:0] user_input, display_value;
   logic [2:0]  state_dbg;
   int          n_chk = 0, n_pass = 0;
   int          m_st;
   logic [31:0] m_user, m_disp;
   logic        m_valid, m_deb, m_press, m_rel;
   bit          hq[$];
   int          lat, lows;

   always #5 CLK = ~CLK;

   io_handshake_ctrl #(.DEBOUNCE_CYCLES(D), .DATA_W(32), .SW_W(16)) dut (
      .CLK(CLK), .reset(reset), .insert(insert), .SW(SW),
      .input_flag(input_flag), .output_flag(output_flag), .halt(halt), .reg_data(reg_data),
      .pc_stall(pc_stall), .user_input(user_input), .display_value(display_value),
      .display_valid(display_valid), .halted(halted), .state_dbg(state_dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] ext(input logic [15:0] s);
`ifdef SW_SIGN_EXT_EN
      return (s >= 16'h8000) ? 32'(s) - 32'h10000 : 32'(s);
`else
      return 32'(s);
`endif
   endfunction

   task automatic m_reset();
      m_st = 0; m_user = '0; m_disp = '0; m_valid = 1'b0;
      m_deb = 1'b0; m_press = 1'b0; m_rel = 1'b0;
      hq.delete();
      for (int k = 0; k < D + 2; k++) hq.push_back(1'b0);
   endtask

   function automatic logic exp_stall();
      if (!reset) return 1'b0;
      if (m_st == 0) return halt | input_flag | output_flag;
      return (m_st != 3 && m_st != 6);
   endfunction

   // one clock edge of the model: button filtered by a window of the last D synchronized samples
   task automatic model_edge();
      bit p, r, flip;
      p = m_press; r = m_rel; flip = 1'b1;
      hq.push_front(insert);
      void'(hq.pop_back());
      for (int j = 2; j < D + 2; j++) if (hq[j] == m_deb) flip = 1'b0;
      m_press = flip && !m_deb;
      m_rel   = flip && m_deb;
      if (flip) m_deb = !m_deb;
      case (m_st)
         0: if (halt) m_st = 7;
            else if (input_flag) m_st = 1;
            else if (output_flag) begin m_st = 4; m_disp = reg_data; m_valid = 1'b1; end
         1: if (p) begin m_user = ext(SW); m_st = 2; end
         2: if (r) m_st = 3;
         4: if (p) m_st = 5;
         5: if (r) m_st = 6;
         3, 6: m_st = 0;
         default: ;
      endcase
   endtask

   task automatic step();
      #1;
      chk("pc_stall", 32'(pc_stall), 32'(exp_stall()));
      chk("state_dbg", 32'(state_dbg), m_st);
      chk("user_input", user_input, m_user);
      chk("display_value", display_value, m_disp);
      chk("display_valid", 32'(display_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_st == 7));
      @(posedge CLK);
      if (reset) model_edge();
      @(negedge CLK);
   endtask

   task automatic hold(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      reset = 1'b0; m_reset(); step(); reset = 1'b1;
   endtask

   task automatic wait_st(input logic [2:0] s, input string name);
      int c = 0;
      while (state_dbg != s && c < 40) begin step(); c++; end
      chk(name, 32'(state_dbg), 32'(s));
   endtask

   task automatic io_txn(input int hold_cyc, input logic [15:0] sw_after, output int l, output int lw);
      insert = 1'b1; l = 0;
      while (state_dbg != 3'd2 && state_dbg != 3'd5 && l < 40) begin step(); l++; end
      SW = sw_after;
      for (int k = l; k < hold_cyc; k++) step();
      insert = 1'b0; lw = 0;
      for (int k = 0; k < 15; k++) begin step(); if (!pc_stall) lw++; end
   endtask

   typedef struct { logic h, i, o, stall; logic [2:0] st; logic valid; } vec_t;
   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl = '{
         '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1},
         '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0},
         '{1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0},
         '{1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0}
      };
      m_reset();
      #2;
      do_reset();
      chk("reset_state", 32'(state_dbg), 32'd0);
      chk("reset_valid", 32'(display_valid), 32'd0);

      // RUN decode: priority halt > input > output
      for (int k = 0; k < 8; k++) begin
         do_reset();
         halt = tbl[k].h; input_flag = tbl[k].i; output_flag = tbl[k].o;
         reg_data = 32'hC0DE_0000 + k;
         #1 chk("tbl_stall", 32'(pc_stall), 32'(tbl[k].stall));
         step();
         chk("tbl_state", 32'(state_dbg), 32'(tbl[k].st));
         chk("tbl_valid", 32'(display_valid), 32'(tbl[k].valid));
      end
      halt = 1'b0; input_flag = 1'b0; output_flag = 1'b0;

      // input handshake, press latency and single commit cycle
      do_reset();
      SW = 16'h00A5; input_flag = 1'b1; step();
      chk("in_wait_state", 32'(state_dbg), 32'd1);
      io_txn(10, 16'h00A5, lat, lows);
      chk("press_latency", lat, 32'd7);
      chk("in_user_input", user_input, 32'h0000_00A5);
      chk("in_commit_lows", lows, 32'd1);
      chk("in_restall", 32'(state_dbg), 32'd1);

      // switches ignored once the press is accepted
      SW = 16'h005A;
      io_txn(10, 16'h1234, lat, lows);
      chk("sw_ignored", user_input, 32'h0000_005A);

      // asynchronous reset in the middle of IN_WAIT_REL
      insert = 1'b1;
      wait_st(3'd2, "reach_in_wait_rel");
      #2 reset = 1'b0; m_reset();
      #1;
      chk("async_rst_state", 32'(state_dbg), 32'd0);
      chk("async_rst_stall", 32'(pc_stall), 32'd0);
      chk("async_rst_user", user_input, 32'd0);
      chk("async_rst_valid", 32'(display_valid), 32'd0);
      step();
      reset = 1'b1; insert = 1'b0; input_flag = 1'b0;
      hold(8);

      // output handshake and display hold
      do_reset();
      output_flag = 1'b1; reg_data = 32'hDEAD_BEEF; step();
      chk("out_disp", display_value, 32'hDEAD_BEEF);
      chk("out_valid", 32'(display_valid), 32'd1);
      chk("out_state", 32'(state_dbg), 32'd4);
      reg_data = 32'h1234_5678; hold(5);
      chk("out_disp_held", display_value, 32'hDEAD_BEEF);
      chk("out_stall_held", 32'(pc_stall), 32'd1);
      io_txn(10, SW, lat, lows);
      chk("out_commit_lows", lows, 32'd1);
      chk("out_next_disp", display_value, 32'h1234_5678);
      output_flag = 1'b0;

      // bounces and a short pulse are filtered
      do_reset();
      input_flag = 1'b1; step();
      for (int k = 0; k < 3; k++) begin insert = 1'b1; step(); insert = 1'b0; step(); end
      insert = 1'b1; hold(D - 1); insert = 1'b0; hold(8);
      chk("bounce_state", 32'(state_dbg), 32'd1);
      chk("bounce_stall", 32'(pc_stall), 32'd1);

      // a button already held when the instruction arrives must be re-pressed
      do_reset();
      input_flag = 1'b0; insert = 1'b1; hold(10);
      input_flag = 1'b1; hold(10);
      chk("held_press_ignored", 32'(state_dbg), 32'd1);
      insert = 1'b0; hold(10);
      chk("held_release_ignored", 32'(state_dbg), 32'd1);
      io_txn(10, SW, lat, lows);
      chk("repress_latency", lat, 32'd7);

      // halt freezes until reset
      do_reset();
      halt = 1'b1; input_flag = 1'b1; step();
      chk("halt_state", 32'(state_dbg), 32'd7);
      chk("halt_flag", 32'(halted), 32'd1);
      halt = 1'b0; input_flag = 1'b0;
      insert = 1'b1; hold(10); insert = 1'b0; hold(10);
      chk("halt_ignores_btn", 32'(state_dbg), 32'd7);
      chk("halt_stall", 32'(pc_stall), 32'd1);
      do_reset();
      chk("halt_cleared", 32'(halted), 32'd0);

      // switch extension
      SW = 16'h8000; input_flag = 1'b1; step();
      io_txn(10, 16'h8000, lat, lows);
`ifdef SW_SIGN_EXT_EN
      chk("sw_extend", user_input, 32'hFFFF_8000);
`else
      chk("sw_extend", user_input, 32'h0000_8000);
`endif

      // randomized traffic against the model
      begin
         int run = 0;
         for (int n = 0; n < 3000; n++) begin
            if (run == 0) begin insert = 1'($urandom_range(0, 1)); run = $urandom_range(1, 12); end
            run--;
            input_flag  = ($urandom_range(0, 3) == 0);
            output_flag = ($urandom_range(0, 3) == 0);
            halt        = ($urandom_range(0, 600) == 0);
            SW          = 16'($urandom);
            reg_data    = $urandom;
            if ($urandom_range(0, 250) == 0) do_reset();
            else step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
